rob_multiport: RTL and testbench

//  Parametrised reorder buffer for the out-of-order core: NW-wide dispatch into rows, NC completion ports, branch-mask kill, in-order row commit.

---
 rtl/rob_multiport_pkg.sv | 32 +++
 rtl/rob_multiport_if.sv | 39 +++
 rtl/rob_multiport_row.sv | 77 +++++++
 rtl/rob_multiport.sv | 113 +++++++++++
 tb/tb_rob_multiport.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rob_multiport_pkg.sv
// Shared widths, cmp-port field layout and slot record for the ROB.
// Imported by the interface, the row sub-module and the top.
package rob_multiport_pkg;

    localparam int NW         = 4;
    localparam int WIDTH_BANK = 3;
    localparam int WIDTH_REG  = 7;
    localparam int WIDTH_BRM  = 4;
    localparam int NC         = 4;
    localparam int SW         = $clog2(NW);
    localparam int DEPTH      = 2 ** WIDTH_BANK;

    // one completion port is {en, row, slot}
    localparam int CW = 1 + WIDTH_BANK + SW;

    typedef logic [WIDTH_BANK-1:0] row_t;
    typedef logic [SW-1:0]         slot_idx_t;

    typedef struct packed {
        logic                 en;
        row_t                 row;
        slot_idx_t            slot;
    } cmp_t;

    typedef struct packed {
        logic                 val;
        logic                 busy;
        logic [WIDTH_REG-1:0] prd;
        logic [WIDTH_BRM-1:0] brm;
    } slot_t;

endpackage

// File: rtl/rob_multiport_if.sv
// Dispatch / completion / kill / commit bundle of the ROB.
// master: rename/dispatch side, slave: the ROB itself.
interface rob_multiport_if;
    import rob_multiport_pkg::*;

    logic                      i_dis_we;
    logic [31:0]               i_dis_pc;
    logic [NW-1:0]             i_dis_val;
    logic [NW*WIDTH_REG-1:0]   i_dis_prd;
    logic [NW*WIDTH_BRM-1:0]   i_dis_brm;
    logic                      o_dis_ready;
    logic [WIDTH_BANK-1:0]     o_dis_tag;
    logic [NC*CW-1:0]          i_cmp;
    logic [WIDTH_BRM:0]        i_kill;
    logic                      o_com_en;
    logic [NW-1:0]             o_com_val;
    logic [NW*WIDTH_REG-1:0]   o_com_prd;
    logic [31:0]               o_com_pc;
    logic [WIDTH_BANK:0]       o_count;

    modport master (
        output i_dis_we, i_dis_pc, i_dis_val,
        output i_dis_prd, i_dis_brm,
        output i_cmp, i_kill,
        input  o_dis_ready, o_dis_tag,
        input  o_com_en, o_com_val,
        input  o_com_prd, o_com_pc, o_count
    );

    modport slave (
        input  i_dis_we, i_dis_pc, i_dis_val,
        input  i_dis_prd, i_dis_brm,
        input  i_cmp, i_kill,
        output o_dis_ready, o_dis_tag,
        output o_com_en, o_com_val,
        output o_com_prd, o_com_pc, o_count
    );

endinterface

// File: rtl/rob_multiport_row.sv
// One ROB row of NW slots: write, busy clear, kill, retire, ready.
// Ports: we/pc/val/prd/brm write, clr_i busy-clear, kill, retire_i.
module rob_multiport_row
    import rob_multiport_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    alloc_i,
    input  logic                    we_i,
    input  logic [31:0]             pc_i,
    input  logic [NW-1:0]           val_i,
    input  logic [NW*WIDTH_REG-1:0] prd_i,
    input  logic [NW*WIDTH_BRM-1:0] brm_i,
    input  logic [NW-1:0]           clr_i,
    input  logic                    kill_en_i,
    input  logic [WIDTH_BRM-1:0]    kill_mask_i,
    input  logic                    retire_i,
    output slot_t [NW-1:0]          slots_o,
    output logic [31:0]             pc_o,
    output logic                    rdy_o
);

    slot_t [NW-1:0] slots_q, slots_d;
    logic [31:0]    pc_q, pc_d;

    always_comb begin
        slots_d = slots_q;
        pc_d    = pc_q;
        if (we_i) begin
            pc_d = pc_i;
            for (int s = 0; s < NW; s++) begin
                slots_d[s].val  = val_i[s];
                slots_d[s].busy = val_i[s];
                slots_d[s].prd  =
                    prd_i[s*WIDTH_REG +: WIDTH_REG];
                slots_d[s].brm  =
                    brm_i[s*WIDTH_BRM +: WIDTH_BRM];
            end
        end else if (alloc_i) begin
            for (int s = 0; s < NW; s++) begin
                if (clr_i[s] && slots_q[s].val)
                    slots_d[s].busy = 1'b0;
                // kill is applied after clear so it wins
                if (kill_en_i &&
                    |(slots_q[s].brm & kill_mask_i)) begin
                    slots_d[s].val  = 1'b0;
                    slots_d[s].busy = 1'b0;
                end
                if (retire_i) begin
                    slots_d[s].val  = 1'b0;
                    slots_d[s].busy = 1'b0;
                end
            end
        end
    end

    always_comb begin
        rdy_o = 1'b1;
        for (int s = 0; s < NW; s++)
            if (slots_q[s].val && slots_q[s].busy)
                rdy_o = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slots_q <= '0;
            pc_q    <= '0;
        end else begin
            slots_q <= slots_d;
            pc_q    <= pc_d;
        end
    end

    assign slots_o = slots_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/rob_multiport.sv
// Reorder buffer: row dispatch at tail, NC completions, kill, commit.
// Ports: i_clk, i_rst_n, bus (rob_multiport_if.slave).
module rob_multiport
    import rob_multiport_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    rob_multiport_if.slave  bus
);

    localparam logic [WIDTH_BANK:0] FULL =
        (WIDTH_BANK+1)'(DEPTH);

    row_t                head_q, head_d;
    row_t                tail_q, tail_d;
    logic [WIDTH_BANK:0] count_q, count_d;

    logic                dis_fire;
    logic                com_fire;
    logic [DEPTH-1:0]    alloc;
    logic [DEPTH-1:0]    rdy;
    logic [NW-1:0]       clr [DEPTH];
    logic [31:0]         pc [DEPTH];
    slot_t [NW-1:0]      slots [DEPTH];
    cmp_t                cmp [NC];

    assign bus.o_dis_ready = (count_q != FULL);
    assign bus.o_dis_tag   = tail_q;
    assign bus.o_count     = count_q;

    assign dis_fire = bus.i_dis_we && (count_q != FULL);
    assign com_fire = (count_q != '0) && rdy[head_q];

    genvar gp;
    for (gp = 0; gp < NC; gp++) begin : g_cmp
        assign cmp[gp] = bus.i_cmp[gp*CW +: CW];
    end

    always_comb begin
        for (int r = 0; r < DEPTH; r++)
            clr[r] = '0;
        for (int p = 0; p < NC; p++)
            if (cmp[p].en)
                clr[cmp[p].row][cmp[p].slot] = 1'b1;
    end

    genvar g;
    for (g = 0; g < DEPTH; g++) begin : g_row
        // a row is live when its distance from head is below count
        assign alloc[g] =
            {1'b0, row_t'(g) - head_q} < count_q;

        rob_multiport_row u_row (
            .clk_i       (i_clk),
            .rst_ni      (i_rst_n),
            .alloc_i     (alloc[g]),
            .we_i        (dis_fire && tail_q == row_t'(g)),
            .pc_i        (bus.i_dis_pc),
            .val_i       (bus.i_dis_val),
            .prd_i       (bus.i_dis_prd),
            .brm_i       (bus.i_dis_brm),
            .clr_i       (clr[g]),
            .kill_en_i   (bus.i_kill[WIDTH_BRM]),
            .kill_mask_i (bus.i_kill[WIDTH_BRM-1:0]),
            .retire_i    (com_fire && head_q == row_t'(g)),
            .slots_o     (slots[g]),
            .pc_o        (pc[g]),
            .rdy_o       (rdy[g])
        );
    end

    logic [NW-1:0]           com_val;
    logic [NW*WIDTH_REG-1:0] com_prd;

    always_comb begin
        com_val = '0;
        com_prd = '0;
        for (int s = 0; s < NW; s++) begin
            com_val[s] = com_fire && slots[head_q][s].val;
            if (com_fire)
                com_prd[s*WIDTH_REG +: WIDTH_REG] =
                    slots[head_q][s].prd;
        end
    end

    assign bus.o_com_en  = com_fire;
    assign bus.o_com_val = com_val;
    assign bus.o_com_prd = com_prd;
    assign bus.o_com_pc  = com_fire ? pc[head_q] : '0;

    always_comb begin
        head_d = head_q + row_t'(com_fire);
        tail_d = tail_q + row_t'(dis_fire);
        unique case ({dis_fire, com_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_rob_multiport.sv
// Randomised bench for rob_multiport against a queue-based ROB model.
// Directed fill/complete/kill/wrap/reset phases, then random traffic.
module tb_rob_multiport;
    import rob_multiport_pkg::*;

    typedef struct packed {
        row_t                    tag;
        logic [31:0]             pc;
        logic [NW-1:0]           val;
        logic [NW-1:0]           busy;
        logic [NW*WIDTH_REG-1:0] prd;
        logic [NW*WIDTH_BRM-1:0] brm;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    rob_multiport_if bus();

    rob_multiport dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    ent_t rob_q[$];
    int   tail_m;
    int   n_chk;
    int   n_pass;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h exp %0h",
                      tag, got, exp);
    endtask

    function automatic bit exp_com();
        if (rob_q.size() == 0) return 1'b0;
        return (rob_q[0].val & rob_q[0].busy) == '0;
    endfunction

    task automatic check_outputs();
        logic [NW-1:0]           ev;
        logic [NW*WIDTH_REG-1:0] ep;
        logic [31:0]             epc;
        bit                      ce;
        ev  = '0;
        ep  = '0;
        epc = '0;
        ce  = exp_com();
        if (ce) begin
            ev  = rob_q[0].val;
            ep  = rob_q[0].prd;
            epc = rob_q[0].pc;
        end
        chk("count", 64'(bus.o_count), 64'(rob_q.size()));
        chk("ready", 64'(bus.o_dis_ready),
            64'(rob_q.size() != DEPTH));
        chk("tag", 64'(bus.o_dis_tag), 64'(tail_m));
        chk("com_en", 64'(bus.o_com_en), 64'(ce));
        chk("com_val", 64'(bus.o_com_val), 64'(ev));
        chk("com_prd", 64'(bus.o_com_prd), 64'(ep));
        chk("com_pc", 64'(bus.o_com_pc), 64'(epc));
    endtask

    task automatic model_step();
        ent_t e;
        cmp_t c;
        bit   cf;
        bit   df;
        logic [WIDTH_BRM-1:0] km;
        cf = exp_com();
        df = bus.i_dis_we && rob_q.size() != DEPTH;
        if (cf) void'(rob_q.pop_front());
        for (int p = 0; p < NC; p++) begin
            c = bus.i_cmp[p*CW +: CW];
            if (c.en)
                for (int i = 0; i < rob_q.size(); i++)
                    if (rob_q[i].tag == c.row) begin
                        e = rob_q[i];
                        e.busy[c.slot] = 1'b0;
                        rob_q[i] = e;
                    end
        end
        if (bus.i_kill[WIDTH_BRM]) begin
            km = bus.i_kill[WIDTH_BRM-1:0];
            for (int i = 0; i < rob_q.size(); i++) begin
                e = rob_q[i];
                for (int s = 0; s < NW; s++)
                    if ((e.brm[s*WIDTH_BRM +: WIDTH_BRM]
                         & km) != '0) begin
                        e.val[s]  = 1'b0;
                        e.busy[s] = 1'b0;
                    end
                rob_q[i] = e;
            end
        end
        if (df) begin
            e.tag  = row_t'(tail_m);
            e.pc   = bus.i_dis_pc;
            e.val  = bus.i_dis_val;
            e.busy = bus.i_dis_val;
            e.prd  = bus.i_dis_prd;
            e.brm  = bus.i_dis_brm;
            rob_q.push_back(e);
            tail_m = (tail_m + 1) % DEPTH;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle();
        bus.i_dis_we  = 1'b0;
        bus.i_dis_pc  = '0;
        bus.i_dis_val = '0;
        bus.i_dis_prd = '0;
        bus.i_dis_brm = '0;
        bus.i_cmp     = '0;
        bus.i_kill    = '0;
    endtask

    task automatic set_port(input int p, input int row,
                            input int slot);
        cmp_t c;
        c.en   = 1'b1;
        c.row  = row_t'(row);
        c.slot = slot_idx_t'(slot);
        bus.i_cmp[p*CW +: CW] = c;
    endtask

    function automatic logic [NW*WIDTH_REG-1:0]
        row_prd(input int r);
        logic [NW*WIDTH_REG-1:0] v;
        for (int s = 0; s < NW; s++)
            v[s*WIDTH_REG +: WIDTH_REG] =
                WIDTH_REG'(r * NW + s);
        return v;
    endfunction

    task automatic rand_inputs();
        int row;
        bus.i_dis_we  = ($urandom_range(0, 3) != 0);
        bus.i_dis_pc  = $urandom;
        bus.i_dis_val = NW'($urandom);
        bus.i_dis_prd = (NW*WIDTH_REG)'($urandom);
        bus.i_dis_brm = '0;
        for (int s = 0; s < NW; s++)
            if ($urandom_range(0, 3) == 0)
                bus.i_dis_brm[s*WIDTH_BRM +: WIDTH_BRM] =
                    WIDTH_BRM'($urandom);
        bus.i_cmp = '0;
        for (int p = 0; p < NC; p++)
            if ($urandom_range(0, 1) == 1) begin
                if (rob_q.size() > 0 &&
                    $urandom_range(0, 7) != 0)
                    row = int'(rob_q[$urandom_range(0,
                                rob_q.size() - 1)].tag);
                else
                    row = $urandom_range(0, DEPTH - 1);
                set_port(p, row, $urandom_range(0, NW - 1));
            end
        bus.i_kill = '0;
        if ($urandom_range(0, 15) == 0)
            bus.i_kill = {1'b1,
                WIDTH_BRM'(1 << $urandom_range(0, 3))};
    endtask

    task automatic complete_first_busy();
        int p;
        p = 0;
        for (int i = 0; i < rob_q.size(); i++)
            if ((rob_q[i].val & rob_q[i].busy) != '0) begin
                for (int s = 0; s < NW; s++)
                    if (rob_q[i].busy[s]) begin
                        set_port(p, int'(rob_q[i].tag), s);
                        p++;
                    end
                break;
            end
    endtask

    task automatic reset_check();
        chk("rst_count", 64'(bus.o_count), 64'd0);
        chk("rst_ready", 64'(bus.o_dis_ready), 64'd1);
        chk("rst_tag", 64'(bus.o_dis_tag), 64'd0);
        chk("rst_com_en", 64'(bus.o_com_en), 64'd0);
        chk("rst_com_val", 64'(bus.o_com_val), 64'd0);
        chk("rst_com_prd", 64'(bus.o_com_prd), 64'd0);
        chk("rst_com_pc", 64'(bus.o_com_pc), 64'd0);
    endtask

    initial begin
        logic [NW*WIDTH_BRM-1:0] brm3;
        n_chk  = 0;
        n_pass = 0;
        tail_m = 0;
        rst_n  = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        reset_check();
        rst_n = 1'b1;

        // fill: rows 0..7, row 3 slot 1 carries branch bit 1
        brm3 = '0;
        brm3[1*WIDTH_BRM +: WIDTH_BRM] = 4'b0010;
        for (int r = 0; r < DEPTH; r++) begin
            chk("fill_tag", 64'(bus.o_dis_tag), 64'(r));
            idle();
            bus.i_dis_we  = 1'b1;
            bus.i_dis_pc  = 32'(r * 16);
            bus.i_dis_val = '1;
            bus.i_dis_prd = row_prd(r);
            bus.i_dis_brm = (r == 3) ? brm3 : '0;
            cycle();
        end
        chk("fill_count", 64'(bus.o_count), 64'd8);
        chk("fill_ready", 64'(bus.o_dis_ready), 64'd0);

        idle();
        bus.i_dis_we = 1'b1;
        bus.i_dis_pc = 32'hdead;
        cycle();
        chk("full_ignore", 64'(bus.o_count), 64'd8);
        chk("full_tag", 64'(bus.o_dis_tag), 64'd0);

        idle();
        for (int p = 0; p < NC; p++) set_port(p, 0, p);
        cycle();
        chk("r0_en", 64'(bus.o_com_en), 64'd1);
        chk("r0_val", 64'(bus.o_com_val), 64'hf);
        chk("r0_prd", 64'(bus.o_com_prd), 64'(row_prd(0)));
        chk("r0_pc", 64'(bus.o_com_pc), 64'd0);

        idle();
        set_port(0, 1, 0);
        set_port(1, 1, 1);
        set_port(2, 1, 3);
        set_port(3, 2, 0);
        cycle();
        chk("r1_block", 64'(bus.o_com_en), 64'd0);
        idle();
        for (int s = 1; s < NW; s++) set_port(s - 1, 2, s);
        cycle();
        chk("r2_block", 64'(bus.o_com_en), 64'd0);
        chk("r2_count", 64'(bus.o_count), 64'd7);
        idle();
        cycle();
        chk("r1_hold", 64'(bus.o_com_en), 64'd0);

        // kill and completion land on row 3 slot 1 together
        idle();
        for (int p = 0; p < NC; p++) set_port(p, 3, p);
        bus.i_kill = {1'b1, 4'b0010};
        cycle();
        chk("kill_block", 64'(bus.o_com_en), 64'd0);

        idle();
        set_port(0, 1, 2);
        cycle();
        chk("r1_en", 64'(bus.o_com_en), 64'd1);
        chk("r1_pc", 64'(bus.o_com_pc), 64'd16);
        idle();
        cycle();
        chk("r2_pc", 64'(bus.o_com_pc), 64'd32);
        idle();
        cycle();
        chk("r3_en", 64'(bus.o_com_en), 64'd1);
        chk("r3_val", 64'(bus.o_com_val), 64'b1101);
        chk("r3_pc", 64'(bus.o_com_pc), 64'd48);
        idle();
        cycle();
        chk("r4_block", 64'(bus.o_com_en), 64'd0);
        chk("r4_count", 64'(bus.o_count), 64'd4);

        // wrap: bubble rows fill the ROB, then drain while full
        for (int i = 0; i < 28; i++) begin
            idle();
            bus.i_dis_we = 1'b1;
            bus.i_dis_pc = 32'h1000 + 32'(i * 4);
            if (i >= 4) complete_first_busy();
            if (i == 4)
                chk("wrap_full", 64'(bus.o_count), 64'd8);
            cycle();
        end

        for (int i = 0; i < 1500; i++) begin
            rand_inputs();
            cycle();
        end

        // asynchronous reset in the middle of traffic
        rand_inputs();
        #2 rst_n = 1'b0;
        #1 reset_check();
        rob_q.delete();
        tail_m = 0;
        @(posedge clk);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        check_outputs();

        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
